capi_parerr_capture: RTL and testbench

- Collects the registered error pulses from up to nchk parity-check instances and turns them into architected error state.
- Keeps per-checker sticky bits, the identity of the first unmasked error, a saturating error-cycle counter and a single-shot interrupt request with a valid/ready handshake.
- Sits directly downstream of the parity checkers. Its status feeds the MMIO error registers and the PSL error-interrupt path.

---
 rtl/capi_parerr_capture.sv | 133 +++++++++++++
 tb/tb_capi_parerr_capture.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/capi_parerr_capture.sv
`default_nettype none
// ============================================================================
// Module   : capi_parerr_capture
// Brief    : Gathers parity-check error pulses into sticky/first-error/count
//            state and raises a single-shot valid/ready interrupt request.
// Revision : 1.0 - initial release
// ============================================================================
module capi_parerr_capture #(
    parameter int NCHK   = 8,
    parameter int IDW    = 3,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCHK-1:0]   i_err,
    input  logic [NCHK-1:0]   i_mask,
    input  logic              i_clr,
    output logic [NCHK-1:0]   o_sticky,
    output logic              o_first_v,
    output logic [IDW-1:0]    o_first_id,
    output logic [CWIDTH-1:0] o_cnt,
    output logic              o_fatal,
    output logic              o_intr_v,
    input  logic              i_intr_r
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CWIDTH-1:0] c_cnt_max = {CWIDTH{1'b1}};

    state_t             r_state;
    state_t             w_state_next;
    logic [NCHK-1:0]    r_sticky;
    logic               r_first_v;
    logic [IDW-1:0]     r_first_id;
    logic [CWIDTH-1:0]  r_cnt;
    logic               r_fatal;
    logic               r_intr_v;

    logic [NCHK-1:0]    w_u;
    logic               w_any;
    logic [NCHK-1:0]    w_sticky_next;
    logic [IDW-1:0]     w_low_id;
    logic               w_first_v_next;
    logic [IDW-1:0]     w_first_id_next;
    logic [CWIDTH-1:0]  w_cnt_base;
    logic [CWIDTH-1:0]  w_cnt_next;
    logic               w_fatal_next;

    assign w_u           = i_err & ~i_mask;
    assign w_any         = |w_u;
    assign w_sticky_next = (i_clr ? '0 : r_sticky) | i_err;
    assign w_fatal_next  = |(w_sticky_next & ~i_mask);
    assign w_cnt_base    = i_clr ? '0 : r_cnt;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        w_low_id = '0;
        for (int k = NCHK - 1; k >= 0; k--) begin
            if (w_u[k]) begin
                w_low_id = IDW'(k);
            end
        end
    end

    always_comb begin
        w_first_v_next  = r_first_v;
        w_first_id_next = r_first_id;
        if ((!r_first_v || i_clr) && w_any) begin
            w_first_v_next  = 1'b1;
            w_first_id_next = w_low_id;
        end else if (i_clr) begin
            w_first_v_next  = 1'b0;
            w_first_id_next = '0;
        end
    end

    always_comb begin
        w_cnt_next = w_cnt_base;
        if (w_any && (w_cnt_base != c_cnt_max)) begin
            w_cnt_next = w_cnt_base + 1'b1;
        end
    end

    // A clear overrides any acceptance and re-arms, requesting again if an
    // unmasked error lands in the same cycle.
    always_comb begin
        w_state_next = r_state;
        if (i_clr) begin
            w_state_next = w_any ? ST_REQ : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any)    w_state_next = ST_REQ;
                ST_REQ:  if (i_intr_r) w_state_next = ST_DONE;
                ST_DONE: w_state_next = ST_DONE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_sticky   <= '0;
            r_first_v  <= 1'b0;
            r_first_id <= '0;
            r_cnt      <= '0;
            r_fatal    <= 1'b0;
            r_intr_v   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sticky   <= w_sticky_next;
            r_first_v  <= w_first_v_next;
            r_first_id <= w_first_id_next;
            r_cnt      <= w_cnt_next;
            r_fatal    <= w_fatal_next;
            r_intr_v   <= (w_state_next == ST_REQ);
        end
    end

    assign o_sticky   = r_sticky;
    assign o_first_v  = r_first_v;
    assign o_first_id = r_first_id;
    assign o_cnt      = r_cnt;
    assign o_fatal    = r_fatal;
    assign o_intr_v   = r_intr_v;

endmodule
`default_nettype wire

// File: tb/tb_capi_parerr_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_capi_parerr_capture
// Brief    : Directed self-checking bench for capi_parerr_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capi_parerr_capture;

    localparam int NCHK   = 8;
    localparam int IDW    = 3;
    localparam int CWIDTH = 8;

    logic              clk;
    logic              reset;
    logic [NCHK-1:0]   i_err;
    logic [NCHK-1:0]   i_mask;
    logic              i_clr;
    logic [NCHK-1:0]   o_sticky;
    logic              o_first_v;
    logic [IDW-1:0]    o_first_id;
    logic [CWIDTH-1:0] o_cnt;
    logic              o_fatal;
    logic              o_intr_v;
    logic              i_intr_r;

    int n_cmp;
    int n_bad;

    capi_parerr_capture #(
        .NCHK   (NCHK),
        .IDW    (IDW),
        .CWIDTH (CWIDTH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_err      (i_err),
        .i_mask     (i_mask),
        .i_clr      (i_clr),
        .o_sticky   (o_sticky),
        .o_first_v  (o_first_v),
        .o_first_id (o_first_id),
        .o_cnt      (o_cnt),
        .o_fatal    (o_fatal),
        .o_intr_v   (o_intr_v),
        .i_intr_r   (i_intr_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] st, input logic fv,
                             input logic [2:0] fid, input logic [7:0] cn,
                             input logic fa, input logic iv);
        chk({tag, ".sticky"},   32'(o_sticky),   32'(st));
        chk({tag, ".first_v"},  32'(o_first_v),  32'(fv));
        chk({tag, ".first_id"}, 32'(o_first_id), 32'(fid));
        chk({tag, ".cnt"},      32'(o_cnt),      32'(cn));
        chk({tag, ".fatal"},    32'(o_fatal),    32'(fa));
        chk({tag, ".intr_v"},   32'(o_intr_v),   32'(iv));
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        i_err    = '0;
        i_mask   = '0;
        i_clr    = 1'b0;
        i_intr_r = 1'b0;

        repeat (3) step();
        check_all("rst", 8'h00, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (10) step();
        check_all("idle", 8'h00, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

        // First unmasked error pair: lowest index (2) wins.
        i_err = 8'h24;
        step();
        i_err = 8'h00;
        check_all("err24", 8'h24, 1'b1, 3'd2, 8'd1, 1'b1, 1'b1);
        repeat (5) step();
        chk("hold.intr_v", 32'(o_intr_v), 32'd1);
        chk("hold.cnt", 32'(o_cnt), 32'd1);
        i_intr_r = 1'b1;
        step();
        i_intr_r = 1'b0;
        chk("accept.intr_v", 32'(o_intr_v), 32'd0);

        // In DONE: error counted and recorded, no new request.
        i_err = 8'h80;
        step();
        i_err = 8'h00;
        check_all("done80", 8'hA4, 1'b1, 3'd2, 8'd2, 1'b1, 1'b0);
        step();
        chk("done.stay", 32'(o_intr_v), 32'd0);

        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        check_all("clr1", 8'h00, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

        // Masked-only error touches sticky alone.
        i_mask = 8'h01;
        i_err  = 8'h01;
        step();
        i_err  = 8'h00;
        check_all("masked", 8'h01, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        i_mask = 8'h00;
        step();
        chk("unmask.fatal", 32'(o_fatal), 32'd1);
        chk("unmask.cnt", 32'(o_cnt), 32'd0);

        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        i_err = 8'h01;
        repeat (300) step();
        check_all("sat", 8'h01, 1'b1, 3'd0, 8'd255, 1'b1, 1'b1);

        // Clear coinciding with a new error, while REQ is pending.
        i_clr = 1'b1;
        i_err = 8'h10;
        step();
        i_clr = 1'b0;
        i_err = 8'h00;
        check_all("clr_err", 8'h10, 1'b1, 3'd4, 8'd1, 1'b1, 1'b1);

        // Later errors must not move the captured first index.
        i_err = 8'h01;
        step();
        i_err = 8'h00;
        chk("first.hold", 32'(o_first_id), 32'd4);
        chk("first.cnt", 32'(o_cnt), 32'd2);

        // Clear beats simultaneous acceptance.
        i_clr    = 1'b1;
        i_intr_r = 1'b1;
        step();
        i_clr    = 1'b0;
        i_intr_r = 1'b0;
        check_all("clr_acc", 8'h00, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

        i_err = 8'h28;
        step();
        i_err = 8'h00;
        check_all("err28", 8'h28, 1'b1, 3'd3, 8'd1, 1'b1, 1'b1);

        // Asynchronous reset mid-REQ.
        #3;
        reset = 1'b0;
        #1;
        check_all("arst", 8'h00, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        check_all("post_rst", 8'h00, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
